usb_rx_packet_buffer: RTL and testbench

Receive-side consumer of the ULPI protocol state machine. Captures each byte it passes through, marked by a one-cycle `new_byte` strobe with the byte on the internal data bus, into a 66-byte packet register. It closes the packet when `dir` falls or when the buffer fills, and holds the packet for the downstream packet processor until acknowledged. The packet register uses the same MSB-first 528-bit layout that the transmit path consumes.

---
 rtl/usb_rx_packet_buffer.sv | 126 ++++++++++++
 tb/tb_usb_rx_packet_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_buffer.sv
// Receive packet buffer: collects ULPI bytes into an MSB-first packet register until dir falls or it fills.
// Optional CRC16 residual check enabled by defining USB_RX_CRC_CHECK_EN.
module usb_rx_packet_buffer #(
    parameter int MAX_BYTES = 66
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   new_byte,
    input  logic [7:0]             rx_data,
    input  logic                   dir,
    input  logic                   packet_ack,
    output logic [8*MAX_BYTES-1:0] packet_data,
    output logic [6:0]             byte_count,
    output logic                   packet_ready,
    output logic                   overrun,
    output logic                   crc_ok
);

    localparam int PW = 8 * MAX_BYTES;

    typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   data_q, data_d;
    logic [6:0]      count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            dir_q;
    logic            dir_fall;

    assign dir_fall = dir_q & ~dir;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (new_byte) begin
                    data_d            = '0;
                    data_d[PW-1 -: 8] = rx_data;
                    count_d           = 7'd1;
                    overrun_d         = 1'b0;
                    state_d           = COLLECT;
                end
            end
            COLLECT: begin
                if (new_byte) begin
                    data_d[PW - 8 - 8*int'(count_q) +: 8] = rx_data;
                    count_d = count_q + 7'd1;
                end
                // A byte arriving with the dir fall is already folded into data_d above.
                if (dir_fall || (new_byte && (count_d == 7'(MAX_BYTES))))
                    state_d = READY;
            end
            READY: begin
                if (new_byte)
                    overrun_d = 1'b1;
                if (packet_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            dir_q     <= dir;
        end
    end

`ifdef USB_RX_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // The PID byte seeds the register; only the bytes after it are checked.
    always_comb begin
        crc_d = crc_q;
        if (state_q == IDLE && new_byte)
            crc_d = 16'hFFFF;
        else if (state_q == COLLECT && new_byte)
            crc_d = crc16_byte(crc_q, rx_data);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    assign crc_ok = (crc_q == 16'hB001);
`else
    logic crc_ok_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_ok_q <= 1'b0;
        else        crc_ok_q <= 1'b1;
    end

    assign crc_ok = crc_ok_q;
`endif

    assign packet_data  = data_q;
    assign byte_count   = count_q;
    assign packet_ready = (state_q == READY);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_usb_rx_packet_buffer.sv
// Scoreboard bench for usb_rx_packet_buffer: expected packets queued at stimulus, checked when packet_ready rises.
module tb_usb_rx_packet_buffer;

    localparam int MAXB = 66;
    localparam int PW   = 8 * MAXB;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          new_byte;
    logic [7:0]    rx_data;
    logic          dir;
    logic          packet_ack;
    logic [PW-1:0] packet_data;
    logic [6:0]    byte_count;
    logic          packet_ready;
    logic          overrun;
    logic          crc_ok;

    usb_rx_packet_buffer #(.MAX_BYTES(MAXB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .new_byte     (new_byte),
        .rx_data      (rx_data),
        .dir          (dir),
        .packet_ack   (packet_ack),
        .packet_data  (packet_data),
        .byte_count   (byte_count),
        .packet_ready (packet_ready),
        .overrun      (overrun),
        .crc_ok       (crc_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]    cnt;
        logic [PW-1:0] data;
        logic          crc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] cur[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       prev_rdy = 1'b0;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] build_data();
        logic [PW-1:0] d;
        d = '0;
        for (int i = 0; i < cur.size(); i++) d[PW-1-8*i -: 8] = cur[i];
        return d;
    endfunction

    function automatic logic crc_expect();
`ifdef USB_RX_CRC_CHECK_EN
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 1; i < cur.size(); i++)
            for (int b = 0; b < 8; b++)
                r = (r[0] ^ cur[i][b]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return (r == 16'hB001);
`else
        return 1'b1;
`endif
    endfunction

    task automatic push_exp();
        exp_t e;
        e.cnt  = 7'(cur.size());
        e.data = build_data();
        e.crc  = crc_expect();
        sb.push_back(e);
    endtask

    // One clock: drive inputs, take the edge, settle 1 time unit past it.
    task automatic cyc(input logic nb, input logic [7:0] d, input logic dv, input logic ak);
        new_byte   = nb;
        rx_data    = d;
        dir        = dv;
        packet_ack = ak;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic dv);
        cur.push_back(d);
        cyc(1'b1, d, dv, 1'b0);
    endtask

    always @(negedge clk) begin
        if (n_rst && packet_ready && !prev_rdy) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pkt", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_count", PW'(byte_count), PW'(mon_e.cnt));
                check("sb_data", packet_data, mon_e.data);
                check("sb_crc_ok", PW'(crc_ok), PW'(mon_e.crc));
            end
        end
        prev_rdy <= packet_ready;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] full_data;
        n_rst = 1'b0; new_byte = 1'b0; rx_data = '0; dir = 1'b0; packet_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", PW'(packet_ready), 0);
        check("rst_count", PW'(byte_count), 0);
        check("rst_data", packet_data, '0);
        check("rst_overrun", PW'(overrun), 0);
        check("rst_crc_ok", PW'(crc_ok), 0);
        n_rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset mid-packet
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        check("mid_count3", PW'(byte_count), 3);
        n_rst = 1'b0;
        #2;
        check("mid_rst_count", PW'(byte_count), 0);
        check("mid_rst_data", packet_data, '0);
        @(posedge clk); #1;
        check("mid_rst_ready", PW'(packet_ready), 0);
        n_rst = 1'b1;
        cur.delete();

        // Short packet, good CRC
        send(8'hC3, 1'b1);
        check("fresh_count1", PW'(byte_count), 1);
        send(8'h00, 1'b1); send(8'h00, 1'b1);
        check("short_not_ready", PW'(packet_ready), 0);
        push_exp();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("short_ready", PW'(packet_ready), 1);
        check("short_top", PW'(packet_data[PW-1 -: 24]), PW'(24'hC30000));
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("short_ack_ready", PW'(packet_ready), 0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Short packet, bad CRC
        cur.delete();
        send(8'hC3, 1'b1); send(8'h00, 1'b1); send(8'h01, 1'b1);
        push_exp();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Full buffer
        cur.delete();
        for (int i = 0; i < MAXB - 1; i++) send(8'(i), 1'b1);
        check("full_not_ready_65", PW'(packet_ready), 0);
        push_exp();
        sb[sb.size()-1].cnt  = 7'(MAXB);
        cur.push_back(8'(MAXB - 1));
        full_data = build_data();
        sb[sb.size()-1].data = full_data;
        sb[sb.size()-1].crc  = crc_expect();
        cyc(1'b1, 8'(MAXB - 1), 1'b1, 1'b0);
        check("full_ready", PW'(packet_ready), 1);
        check("full_count", PW'(byte_count), PW'(MAXB));
        check("full_last", PW'(packet_data[7:0]), PW'(8'h41));
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        check("full_overrun", PW'(overrun), 1);
        check("full_data_held", packet_data, full_data);
        check("full_count_held", PW'(byte_count), PW'(MAXB));
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        check("full_ack_ready", PW'(packet_ready), 0);
        check("idle_overrun_sticky", PW'(overrun), 1);

        // Byte coincident with dir fall
        cur.delete();
        send(8'h4B, 1'b1);
        check("first_clears_overrun", PW'(overrun), 0);
        push_exp();
        sb[sb.size()-1].cnt = 7'd2;
        cur.push_back(8'hAA);
        sb[sb.size()-1].data = build_data();
        sb[sb.size()-1].crc  = crc_expect();
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("sim_ready", PW'(packet_ready), 1);
        check("sim_count", PW'(byte_count), 2);
        check("sim_top", PW'(packet_data[PW-1 -: 16]), PW'(16'h4BAA));

        // Ack and byte together in the first READY cycle, then back-to-back packet
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        check("ack_ready_low", PW'(packet_ready), 0);
        check("ack_overrun", PW'(overrun), 1);
        cur.delete();
        send(8'h69, 1'b1);
        check("b2b_count", PW'(byte_count), 1);
        check("b2b_overrun_clr", PW'(overrun), 0);
        cur.push_back(8'h5A);
        cyc(1'b1, 8'h5A, 1'b1, 1'b1);
        check("ack_outside_ready", PW'(packet_ready), 0);
        check("ack_outside_count", PW'(byte_count), 2);
        push_exp();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("b2b_ready", PW'(packet_ready), 1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);

        // dir fall while idle is ignored
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("idle_dirfall_ready", PW'(packet_ready), 0);
        check("idle_dirfall_count", PW'(byte_count), 2);

        @(negedge clk);
        check("sb_drained", PW'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
